// File: rtl/game_stat_counter_pkg.sv
// Shared types and limits for the snake game statistics counter.
// Holds the game phase encoding plus the display saturation limits.
package snake_stat_pkg;

  localparam int SCORE_W = 11;
  localparam int TIME_W  = 14;

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(999);
  localparam logic [TIME_W-1:0]  TIME_MAX  = TIME_W'(9999);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

endpackage

// File: rtl/game_stat_counter_if.sv
// Event pulses in, display words and phase out, for the statistics counter.
// The master side produces game events; the slave side is the counter itself.
interface game_stat_counter_if;

  logic        start;
  logic        pause_toggle;
  logic        eat;
  logic        game_over;
  logic [31:0] score;
  logic [31:0] total_time;
  logic [31:0] high_score;
  logic [1:0]  state;
  logic        running;

  modport master (
    output start, pause_toggle, eat, game_over,
    input  score, total_time, high_score, state, running
  );

  modport slave (
    input  start, pause_toggle, eat, game_over,
    output score, total_time, high_score, state, running
  );

endinterface

// File: rtl/game_stat_counter_sec_tick_gen.sv
// One-second prescaler: counts CLK_HZ enabled cycles and pulses tick on the last.
// A clear restarts the second from zero and wins over enable.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count_q;

  assign tick = enable && !clear && (count_q == LAST);

  // Holding the count while disabled lets a pause resume mid-second.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_stat_counter.sv
// Snake game statistics: phase FSM, saturating score and elapsed-seconds counters.
// Define GAME_STAT_HIGH_SCORE_EN to build the best-score register; otherwise it reads 0.
module game_stat_counter
  import snake_stat_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int POINTS_PER_FOOD = 1
) (
  input  logic                clock,
  input  logic                reset,
  game_stat_counter_if.slave  bus
);

  localparam logic [SCORE_W-1:0] POINTS = SCORE_W'(POINTS_PER_FOOD);

  game_state_t        state_q, state_d;
  logic               running;
  logic               new_game;
  logic               tick;
  logic [SCORE_W-1:0] score_q, score_d, score_sum;
  logic [TIME_W-1:0]  time_q, time_d;

  assign running  = (state_q == ST_RUN);
  assign new_game = bus.start && ((state_q == ST_IDLE) || (state_q == ST_OVER));

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (running),
    .clear  (new_game),
    .tick   (tick)
  );

  // game_over outranks pause_toggle, so a simultaneous toggle is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.game_over)         state_d = ST_OVER;
        else if (bus.pause_toggle) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.game_over)         state_d = ST_OVER;
        else if (bus.pause_toggle) state_d = ST_RUN;
      end
      ST_OVER:  if (bus.start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Events in RUN still count on the game_over cycle; other phases freeze.
  always_comb begin
    score_sum = score_q + POINTS;
    score_d   = score_q;
    time_d    = time_q;
    if (new_game) begin
      score_d = '0;
      time_d  = '0;
    end else if (running) begin
      if (bus.eat) begin
        score_d = (score_sum > SCORE_MAX) ? SCORE_MAX : score_sum;
      end
      if (tick && (time_q != TIME_MAX)) begin
        time_d = time_q + TIME_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      time_q  <= time_d;
    end
  end

`ifdef GAME_STAT_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic               enter_over;

  assign enter_over = bus.game_over && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

  // Compare against the post-eat score so a final bite still counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_q <= '0;
    end else if (enter_over && (score_d > high_q)) begin
      high_q <= score_d;
    end
  end

  assign bus.high_score = 32'(high_q);
`else
  assign bus.high_score = '0;
`endif

  assign bus.score      = 32'(score_q);
  assign bus.total_time = 32'(time_q);
  assign bus.state      = state_q;
  assign bus.running    = running;

endmodule

// File: tb/tb_game_stat_counter.sv
// Randomized bench for game_stat_counter against an arithmetic model of the game rules.
// Honors GAME_STAT_HIGH_SCORE_EN the same way the design does.
module tb_game_stat_counter;

  localparam int CLK_HZ = 10;
  localparam int POINTS = 100;

  logic clock = 1'b0;
  logic reset = 1'b0;

  game_stat_counter_if bus ();

  game_stat_counter #(
    .CLK_HZ          (CLK_HZ),
    .POINTS_PER_FOOD (POINTS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int vectorCount = 0;
  int missCount   = 0;

  // Model: phase 0..3, score, seconds, cycles into current second, best score.
  int mState = 0;
  int mScore = 0;
  int mTime  = 0;
  int mPre   = 0;
  int mHigh  = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectorCount++;
    if (observed != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic endGame();
    mState = 3;
`ifdef GAME_STAT_HIGH_SCORE_EN
    if (mScore > mHigh) mHigh = mScore;
`endif
  endtask

  task automatic modelStep(input bit s, input bit p, input bit e, input bit g, input bit r);
    bit secDone;
    if (r) begin
      mState = 0; mScore = 0; mTime = 0; mPre = 0; mHigh = 0;
    end else if ((mState == 0 || mState == 3) && s) begin
      mState = 1; mScore = 0; mTime = 0; mPre = 0;
    end else if (mState == 1) begin
      secDone = (mPre == CLK_HZ - 1);
      if (e) mScore = (mScore + POINTS > 999) ? 999 : mScore + POINTS;
      if (secDone && mTime < 9999) mTime = mTime + 1;
      mPre = (mPre + 1) % CLK_HZ;
      if (g) endGame();
      else if (p) mState = 2;
    end else if (mState == 2) begin
      if (g) endGame();
      else if (p) mState = 1;
    end
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit e, input bit g, input bit r);
    @(negedge clock);
    bus.start        = s;
    bus.pause_toggle = p;
    bus.eat          = e;
    bus.game_over    = g;
    reset            = r;
    @(posedge clock);
    modelStep(s, p, e, g, r);
    #1;
    checkOutput("score",      bus.score,      mScore);
    checkOutput("total_time", bus.total_time, mTime);
    checkOutput("state",      bus.state,      mState);
    checkOutput("running",    bus.running,    (mState == 1) ? 1 : 0);
    checkOutput("high_score", bus.high_score, mHigh);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.eat          = 1'b0;
    bus.game_over    = 1'b0;

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 1, 1);

    // First game: seconds tick at 10, 20, 30 cycles after start.
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(35);

    // Score reaches 500, then clamps at 999.
    for (int i = 0; i < 5; i++) begin applyStimulus(0, 0, 1, 0, 0); idleCycles(1); end
    for (int i = 0; i < 6; i++) begin applyStimulus(0, 0, 1, 0, 0); idleCycles(1); end

    // Pause four cycles into a second; the remaining six cycles resume after.
    for (int i = 0; i < 2 * CLK_HZ && mPre != 4; i++) idleCycles(1);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    idleCycles(50);
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(12);

    // Final bite together with collision, then ignored bites and start-ignored checks.
    applyStimulus(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);

    // New game from OVER; start mid-game is ignored; pause with collision drops the toggle.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(3);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 24) == 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 79) == 0,
                    $urandom_range(0, 999) == 0);
    end

    // Reset in the middle of a scoring game.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    idleCycles(4);
    applyStimulus(0, 0, 1, 0, 1);
    idleCycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/game_stat_counter.md
# game_stat_counter

Gameplay statistics counter for the snake game; sits directly upstream of the seven-segment display driver and produces the `score` and `total_time` words it renders. Tracks game phase (idle / running / paused / over), derives a 1 Hz tick from the system clock to count elapsed seconds, and accumulates points on each food-eaten pulse. Both outputs are plain binary, saturated to what the display can show: 3 score digits, 4 time digits.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; one second equals `CLK_HZ` cycles.
- `POINTS_PER_FOOD`, 1: score increment per `eat` pulse; legal range 1..999.
- `clock`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins a new game.
- `pause_toggle`  in  1: single-cycle pulse; toggles between running and paused.
- `eat`  in  1: single-cycle pulse when the snake eats food.
- `game_over`  in  1: single-cycle pulse when the snake collides.
- `score`  out  32: current score, binary, 0..999.
- `total_time`  out  32: elapsed running seconds, binary, 0..9999.
- `high_score`  out  32: best finished score (see Configuration).
- `state`  out  2: phase encoding: IDLE=0, RUN=1, PAUSE=2, OVER=3.
- `running`  out  1: high when `state==RUN`.

## Operation
- States and transitions (one per cycle, evaluated in priority order):
  - IDLE: `start` -> RUN.
  - RUN: `game_over` -> OVER; else `pause_toggle` -> PAUSE.
  - PAUSE: `game_over` -> OVER; else `pause_toggle` -> RUN.
  - OVER: `start` -> RUN.
- `start` in RUN or PAUSE is ignored.
- Entering RUN from IDLE or OVER clears `score`, `total_time` and the prescaler in the same edge. Resuming from PAUSE clears nothing.
- Prescaler:
  - Counts 0..`CLK_HZ`-1 only while in RUN; holds its value in PAUSE.
  - A tick fires on the cycle the count equals `CLK_HZ`-1, and the count wraps to 0.
- Tick in RUN: `total_time` increments by 1 and saturates at 9999.
- `eat` in RUN: `score` increments by `POINTS_PER_FOOD` and saturates at 999 (clamped, never wraps).
- `eat` outside RUN is ignored.
- Simultaneous events:
  - `eat` or a tick in the same cycle as `game_over` in RUN is still counted; the state then moves to OVER.
  - `pause_toggle` in the same cycle as `game_over` is ignored.
- OVER and PAUSE hold `score` and `total_time` frozen for display.
- Arithmetic uses an 11-bit internal score and a 14-bit internal time. Outputs are zero-extended to 32 bits.

## Timing
- Reset values: `score`=0, `total_time`=0, `high_score`=0, `state`=IDLE, `running`=0, prescaler=0.
- `reset` has priority over every input and takes effect on the next edge, including mid-game.
- All outputs are registered:
  - An input pulse at edge N is visible on outputs after edge N.
  - The first tick after entering RUN occurs `CLK_HZ` cycles after the entry edge.
- There are no handshakes: pulses are assumed one cycle wide and already synchronised to `clock`. A level held high acts on every cycle it is high.

## Configuration
- `GAME_STAT_HIGH_SCORE_EN` defined:
  - On every transition into OVER, `high_score` loads the final score (including an `eat` in the same cycle) if that score is strictly greater than the current `high_score`.
  - `high_score` is cleared only by `reset`.
- Not defined: `high_score` is tied to 0 and no register is built.

## Structure
- Shared package `snake_stat_pkg` holds:
  - The state typedef and encodings listed under Operation.
  - `SCORE_MAX`=999 and `TIME_MAX`=9999.
  - The internal widths `SCORE_W`=11 and `TIME_W`=14.
- Sub-module `sec_tick_gen`:
  - Parameter `CLK_HZ`; inputs `clock`, `reset`, `enable`, `clear`; output `tick`.
  - `clear` overrides `enable`.
  - The top level drives `enable`=running and `clear`=new-game entry.

## Test plan
Use `CLK_HZ`=10 in simulation.
- Reset, then `start`, then 35 idle cycles -> `state`=1; `total_time` reads 1, 2, 3 at 10, 20 and 30 cycles after the `start` edge.
- In RUN, 5 `eat` pulses with `POINTS_PER_FOOD`=100, then 6 more -> `score` reads 500, then saturates at 999.
- `pause_toggle` 4 cycles into a second, wait 50 cycles, toggle again -> `total_time` unchanged during pause; next tick arrives 6 cycles after resume.
- `eat` and `game_over` in the same cycle with `score`=7 -> `score`=8, `state`=3; later `eat` pulses are ignored.
- From OVER, `start` -> `score`=0, `total_time`=0, `state`=1; with the macro defined, `high_score`=8 and is retained.
- Assert `reset` mid-game with `score`=42 -> the next edge gives all outputs 0 and `state`=0, including `high_score`.
